// File: rtl/bc_broadcast_buffer_pkg.sv
// rtl/bc_broadcast_buffer_pkg.sv - shared types and defaults for the lane broadcast buffer (BC_BUF_REPLAY_EN adds the REPLAY state)
package bc_broadcast_buffer_pkg;

    localparam int ELEN       = 64;
    localparam int BcBufDepth = 8;
    localparam int BcLenWidth = 16;

    typedef logic [ELEN-1:0] elen_t;

    typedef struct packed {
        logic [BcLenWidth-1:0] len;
        logic [7:0]            rep;
    } bc_cmd_t;

    typedef enum logic [1:0] {
        BC_IDLE,
        BC_STREAM
`ifdef BC_BUF_REPLAY_EN
        , BC_REPLAY
`endif
    } bc_state_e;

endpackage

// File: rtl/bc_broadcast_buffer_ring.sv
// rtl/bc_broadcast_buffer_ring.sv - Depth x elen_t ring storage with wr/rd pointers, count, full/empty
module bc_buf_ring
    import bc_broadcast_buffer_pkg::*;
#(
    parameter int Depth = BcBufDepth
) (
    input  logic  clk_i,
    input  logic  rst_ni,
    input  logic  clr,
    input  logic  push,
    input  elen_t wdata,
    input  logic  pop,
    input  logic  keep,
    input  logic  rewind,
    output elen_t rdata,
    output logic  full,
    output logic  empty
);

    localparam int AW = $clog2(Depth);
    localparam logic [AW:0] DepthC = (AW+1)'(Depth);

    elen_t         mem [Depth];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          free;

    // A pop only frees its slot when the entries are not being retained for replay
    assign free  = pop && !keep;
    assign rdata = mem[rd_ptr];
    assign full  = (count == DepthC);
    assign empty = (count == '0);

    // Storage write; contents need no reset since validity is tracked by count
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // Pointer and occupancy tracking; pointers wrap naturally at the power-of-two depth
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rewind) begin
                rd_ptr <= '0;
            end else if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !free) begin
                count <= count + 1'b1;
            end else if (!push && free) begin
                count <= count - 1'b1;
            end
        end
    end

endmodule

// File: rtl/bc_broadcast_buffer.sv
// rtl/bc_broadcast_buffer.sv - lane broadcast chain transmit buffer; optional replay via BC_BUF_REPLAY_EN
module bc_broadcast_buffer
    import bc_broadcast_buffer_pkg::*;
#(
    parameter int NrLanes  = 4,
    parameter int Depth    = BcBufDepth,
    parameter int LenWidth = BcLenWidth
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                cmd_valid_i,
    output logic                cmd_ready_o,
    input  logic [LenWidth-1:0] cmd_len_i,
    input  logic [7:0]          cmd_rep_i,
    input  logic                src_valid_i,
    output logic                src_ready_o,
    input  elen_t               src_data_i,
    output logic                bc_valid_o,
    input  logic                bc_ready_i,
    output elen_t               bc_data_o,
    output logic                busy_o,
    output logic                done_o
);

    if (NrLanes < 1 || Depth < 2 || (Depth & (Depth - 1)) != 0) begin : g_param_check
        $error("bc_broadcast_buffer: NrLanes must be >=1 and Depth a power of two >=2");
    end

    bc_state_e           state_q, state_d;
    logic [LenWidth-1:0] len_q;
    logic [LenWidth-1:0] rx_cnt;
    logic [LenWidth-1:0] tx_cnt;
    logic                done_q;
    logic                cmd_fire, push, bc_fire, last_tx, final_tx;
    logic                keep, rewind, ring_full, ring_empty;
    elen_t               ring_rdata;

    assign cmd_ready_o = (state_q == BC_IDLE);
    assign busy_o      = (state_q != BC_IDLE);
    assign done_o      = done_q;
    assign cmd_fire    = cmd_valid_i && cmd_ready_o;
    assign push        = src_valid_i && src_ready_o;
    assign bc_fire     = bc_valid_o && bc_ready_i;
    assign last_tx     = bc_fire && (tx_cnt == len_q - LenWidth'(1));
    assign bc_data_o   = bc_valid_o ? ring_rdata : '0;

`ifdef BC_BUF_REPLAY_EN
    localparam logic [LenWidth-1:0] DepthL = LenWidth'(Depth);
    logic       keep_q;
    logic [7:0] pass_cnt;

    assign keep        = keep_q;
    assign rewind      = last_tx && keep_q;
    assign src_ready_o = (state_q == BC_STREAM) && (rx_cnt < len_q)
                         && (keep_q ? (rx_cnt < DepthL) : !ring_full);
    assign bc_valid_o  = ((state_q == BC_STREAM) && (keep_q ? (tx_cnt < rx_cnt) : !ring_empty))
                         || (state_q == BC_REPLAY);
    assign final_tx    = last_tx && ((state_q == BC_STREAM) ? !keep_q : (pass_cnt == 8'd1));

    // Replay bookkeeping: whether this command replays and how many passes remain
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            keep_q   <= 1'b0;
            pass_cnt <= '0;
        end else if (cmd_fire) begin
            keep_q   <= (cmd_rep_i != '0) && (cmd_len_i != '0) && (cmd_len_i <= DepthL);
            pass_cnt <= cmd_rep_i;
        end else if (state_q == BC_REPLAY && last_tx) begin
            pass_cnt <= pass_cnt - 8'd1;
        end
    end
`else
    logic unused_rep;

    assign unused_rep  = ^cmd_rep_i;
    assign keep        = 1'b0;
    assign rewind      = 1'b0;
    assign src_ready_o = (state_q == BC_STREAM) && (rx_cnt < len_q) && !ring_full;
    assign bc_valid_o  = (state_q == BC_STREAM) && !ring_empty;
    assign final_tx    = last_tx;
`endif

    bc_buf_ring #(
        .Depth(Depth)
    ) u_ring (
        .clk_i (clk_i),
        .rst_ni(rst_ni),
        .clr   (cmd_fire),
        .push  (push),
        .wdata (src_data_i),
        .pop   (bc_fire),
        .keep  (keep),
        .rewind(rewind),
        .rdata (ring_rdata),
        .full  (ring_full),
        .empty (ring_empty)
    );

    // State register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= BC_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: a zero-length command never leaves IDLE
    always_comb begin
        state_d = state_q;
        case (state_q)
            BC_IDLE: begin
                if (cmd_fire && cmd_len_i != '0) begin
                    state_d = BC_STREAM;
                end
            end
            BC_STREAM: begin
                if (last_tx) begin
`ifdef BC_BUF_REPLAY_EN
                    state_d = keep_q ? BC_REPLAY : BC_IDLE;
`else
                    state_d = BC_IDLE;
`endif
                end
            end
`ifdef BC_BUF_REPLAY_EN
            BC_REPLAY: begin
                if (final_tx) begin
                    state_d = BC_IDLE;
                end
            end
`endif
            default: state_d = BC_IDLE;
        endcase
    end

    // Command latch, element counters and the completion pulse
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            len_q  <= '0;
            rx_cnt <= '0;
            tx_cnt <= '0;
            done_q <= 1'b0;
        end else begin
            done_q <= (cmd_fire && cmd_len_i == '0) || final_tx;
            if (cmd_fire) begin
                len_q  <= cmd_len_i;
                rx_cnt <= '0;
                tx_cnt <= '0;
            end else begin
                if (push) begin
                    rx_cnt <= rx_cnt + LenWidth'(1);
                end
                if (last_tx) begin
                    tx_cnt <= '0;
                end else if (bc_fire) begin
                    tx_cnt <= tx_cnt + LenWidth'(1);
                end
            end
        end
    end

endmodule
